// File: rtl/bullet_update_engine.sv
// ---------------------------------------------------------------------------
// bullet_update_engine
//
// Purpose:
//   Moves every bullet stored in BulletRAM once per video frame so the CPU
//   does not have to. The engine owns the single BulletRAM port and shares
//   it with the CPU. The CPU always wins; the engine only uses idle cycles
//   for its per-frame read-modify-write sweep. Bullets that leave the
//   X_MAX x Y_MAX playfield are retired by clearing their active bit.
//
// Entry layout (32 bits):
//   [31] active, [30:21] x, [20:11] y, [10:6] vx (signed), [5:1] vy (signed),
//   [0] owner
//
// Ports:
//   clk          system clock, sole clock
//   reset        asynchronous active-high reset
//   enable       a sweep may only start while high
//   frame_start  one-cycle pulse at the start of vertical blank
//   cpu_wEn      CPU write strobe
//   cpu_readEn   CPU read strobe
//   cpu_addr     CPU entry index
//   cpu_dataIn   CPU write data
//   cpu_dataOut  CPU read data, valid one cycle after cpu_readEn and held
//                until the next CPU read
//   ram_wEn      BulletRAM write enable
//   ram_readEn   BulletRAM read enable
//   ram_addr     BulletRAM index
//   ram_dataIn   BulletRAM write data
//   ram_dataOut  BulletRAM read data, valid one cycle after ram_readEn
//   busy         high while a sweep is in progress
//   done         one-cycle pulse when a sweep completes
//   overrun      sticky: frame_start seen while busy; cleared only by reset
// ---------------------------------------------------------------------------
module bullet_update_engine #(
  parameter int DEPTH         = 64,
  parameter int ADDRESS_WIDTH = 6,
  parameter int X_MAX         = 640,
  parameter int Y_MAX         = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     frame_start,
  input  logic                     cpu_wEn,
  input  logic                     cpu_readEn,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [31:0]              cpu_dataIn,
  output logic [31:0]              cpu_dataOut,
  output logic                     ram_wEn,
  output logic                     ram_readEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [31:0]              ram_dataIn,
  input  logic [31:0]              ram_dataOut,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  // Sweep states
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WT   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic signed [10:0]       X_LIMIT  = 11'(X_MAX);
  localparam logic signed [10:0]       Y_LIMIT  = 11'(Y_MAX);

  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]              entry_q, entry_d;
  logic [31:0]              hold_q;
  logic                     cpuRdD1_q;
  logic                     overrun_q;

  logic                     cpuAccess;
  logic                     cpuHitsIdx;
  logic                     lastIdx;
  logic [2:0]               advanceState;
  logic [ADDRESS_WIDTH-1:0] advanceIdx;
  logic                     engRead;
  logic                     engWrite;

  logic signed [10:0]       posX, posY, velX, velY, nextX, nextY;
  logic                     offField;
  logic [31:0]              movedEntry;

  // Any CPU strobe claims the RAM port for this cycle.
  assign cpuAccess = cpu_wEn | cpu_readEn;

  // A CPU write to the entry the engine is working on makes the engine's
  // copy stale, so the engine drops its write for that entry.
  assign cpuHitsIdx = cpu_wEn && (cpu_addr == idx_q);

  // Step to the next entry, or finish after the last one (no wrap).
  assign lastIdx      = (idx_q == LAST_IDX);
  assign advanceState = lastIdx ? DONE : RD;
  assign advanceIdx   = lastIdx ? idx_q : idx_q + 1'b1;

  // Position update at 11 bits signed. Positions are zero-extended, speeds
  // sign-extended. An out-of-range result (including a positive overflow
  // that wraps negative) retires the bullet with its old position kept.
  always_comb begin
    posX       = {1'b0, ram_dataOut[30:21]};
    posY       = {1'b0, ram_dataOut[20:11]};
    velX       = {{6{ram_dataOut[10]}}, ram_dataOut[10:6]};
    velY       = {{6{ram_dataOut[5]}}, ram_dataOut[5:1]};
    nextX      = posX + velX;
    nextY      = posY + velY;
    offField   = (nextX < 11'sd0) || (nextX >= X_LIMIT) ||
                 (nextY < 11'sd0) || (nextY >= Y_LIMIT);
    movedEntry = offField ? {1'b0, ram_dataOut[30:0]}
                          : {ram_dataOut[31], nextX[9:0], nextY[9:0], ram_dataOut[10:0]};
  end

  // Sweep sequencing. RD and WR wait politely for a CPU-free cycle; WT uses
  // no port and always moves on.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    entry_d  = entry_q;
    engRead  = 1'b0;
    engWrite = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start && enable) begin
          idx_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (!cpuAccess) begin
          engRead = 1'b1;
          state_d = WT;
        end
      end
      WT: begin
        entry_d = movedEntry;
        if (cpuHitsIdx || !ram_dataOut[31]) begin
          idx_d   = advanceIdx;
          state_d = advanceState;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        if (cpuHitsIdx) begin
          idx_d   = advanceIdx;
          state_d = advanceState;
        end else if (!cpuAccess) begin
          engWrite = 1'b1;
          idx_d    = advanceIdx;
          state_d  = advanceState;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM port mux: CPU strobes pass straight through. A simultaneous
  // read and write from the CPU is treated as a write.
  always_comb begin
    if (cpuAccess) begin
      ram_wEn    = cpu_wEn;
      ram_readEn = cpu_readEn & ~cpu_wEn;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_dataIn;
    end else begin
      ram_wEn    = engWrite;
      ram_readEn = engRead;
      ram_addr   = idx_q;
      ram_dataIn = entry_q;
    end
  end

  // State, sweep index, entry buffer, CPU read pipeline and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      entry_q   <= '0;
      hold_q    <= '0;
      cpuRdD1_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      entry_q   <= entry_d;
      cpuRdD1_q <= cpu_readEn;
      if (cpuRdD1_q) begin
        hold_q <= ram_dataOut;
      end
      if (frame_start && busy) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // CPU sees fresh RAM data in the cycle after its read, the held copy
  // otherwise.
  assign cpu_dataOut = cpuRdD1_q ? ram_dataOut : hold_q;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign overrun = overrun_q;

endmodule

// File: doc/bullet_update_engine.md
Name: bullet_update_engine

Overview:
- Hardware scheduler that advances every bullet in BulletRAM once per video frame, so the CPU no longer moves bullets in software.
- Sits between the CPU data bus and the single BulletRAM port. It arbitrates that port between CPU accesses, which always win, and its own per-frame read-modify-write sweep over all entries.
- Bullets that leave the 640x480 playfield are retired by clearing their active bit.

Parameters:
- DEPTH, 64, number of BulletRAM entries swept.
- ADDRESS_WIDTH, 6, BulletRAM index width (log2 DEPTH).
- X_MAX, 640, exclusive upper bound of x.
- Y_MAX, 480, exclusive upper bound of y.

Ports:
- clk  in  1  system clock (25 MHz domain); sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  sweeps start only while high.
- frame_start  in  1  one-cycle pulse at vertical blank start.
- cpu_wEn  in  1  CPU write strobe to BulletRAM.
- cpu_readEn  in  1  CPU read strobe to BulletRAM.
- cpu_addr  in  ADDRESS_WIDTH  CPU entry index.
- cpu_dataIn  in  32  CPU write data.
- cpu_dataOut  out  32  CPU read data; valid 1 cycle after cpu_readEn, held until next CPU read.
- ram_wEn  out  1  BulletRAM write enable.
- ram_readEn  out  1  BulletRAM read enable.
- ram_addr  out  ADDRESS_WIDTH  BulletRAM index.
- ram_dataIn  out  32  BulletRAM write data.
- ram_dataOut  in  32  BulletRAM read data; synchronous, valid 1 cycle after ram_readEn.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- overrun  out  1  sticky flag: frame_start arrived while busy; cleared only by reset.

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0, the FSM goes to IDLE, the index to 0, and the hold register to 0.

Entry format:
- [31] active
- [30:21] x, unsigned 10b
- [20:11] y, unsigned 10b
- [10:6] vx, signed 5b
- [5:1] vy, signed 5b
- [0] owner

Arbitration:
- A CPU access is any cycle with cpu_wEn or cpu_readEn high.
- When a CPU access occurs, the ram_* outputs are driven combinationally from the cpu_* inputs in that same cycle, and the engine issues nothing.
- The CPU never stalls.
- If cpu_wEn and cpu_readEn are both high, the write takes effect.

CPU read path:
- cpu_rd_d1 is cpu_readEn delayed by one cycle.
- When cpu_rd_d1 = 1, cpu_dataOut = ram_dataOut and the hold register captures that value.
- Otherwise cpu_dataOut = the hold register value.

FSM states: IDLE, RD, WT, WR, DONE.
- IDLE: on frame_start && enable, set idx = 0, busy = 1, go to RD.
- RD: if no CPU access, assert ram_readEn with ram_addr = idx and go to WT; otherwise stay in RD.
- WT: capture ram_dataOut into the entry register.
  - If the entry is inactive, go to next-index.
  - If the entry is active, compute the new position and go to WR.
- WR: if no CPU access, assert ram_wEn with ram_addr = idx and ram_dataIn = the updated entry, then go to next-index; otherwise stay in WR.
- Next-index: if idx == DEPTH-1 go to DONE, otherwise increment idx and go to RD.
- DONE: pulse done for 1 cycle, set busy = 0, go to IDLE.

Update arithmetic:
- Compute at 11 bits signed: nx = x + sext(vx), ny = y + sext(vy).
- If nx < 0, nx >= X_MAX, ny < 0 or ny >= Y_MAX: write the entry back with bit31 = 0 and the old x/y unchanged.
- Otherwise write the entry with x = nx[9:0], y = ny[9:0]; all other fields unchanged.

Coherency:
- A CPU write to cpu_addr == idx while the FSM is in WT or WR cancels the engine write for that entry. The CPU value stands and the FSM goes to next-index.

Timing:
- Uncontended cost is 3 cycles per active entry and 2 per inactive entry, so a full sweep takes at most 192 cycles plus DONE.

Boundary cases:
- frame_start while busy: ignored, and overrun is set.
- enable falling mid-sweep: the sweep completes anyway.
- reset mid-sweep: abort immediately; a partially updated table is acceptable.
- idx does not wrap; the sweep terminates at DEPTH-1.

Test Plan:
- Move: entry 5 = {1, x=100, y=50, vx=+3, vy=-2, 0}, pulse frame_start -> entry 5 holds x=103, y=48, active=1; done pulses once; busy falls within 194 cycles.
- Retire: entry 0 with x=638, vx=+3, and entry 1 with y=1, vy=-2, one sweep -> both have bit31 = 0 with x/y unchanged; inactive entry 2 is never written (ram_wEn never asserted with ram_addr = 2).
- Contention: hold cpu_readEn high for 10 cycles during the sweep -> the engine issues no ram strobes in those cycles; CPU data is correct 1 cycle after each read; the sweep finishes with all updates correct.
- Coherency: CPU writes 0xDEADBEEF to entry idx while the FSM is in WR -> the entry reads back 0xDEADBEEF and the engine write is skipped.
- Overrun/enable: second frame_start at cycle 20 of a sweep -> overrun = 1 and stays 1; with enable = 0, frame_start -> busy stays 0 and there is no RAM activity.
- Reset: assert reset mid-sweep -> busy, done, overrun, ram_wEn and ram_readEn are 0 immediately with no clock edge needed; the next frame_start starts a sweep from idx 0.
